fp_mul_iter: RTL and testbench

Parametrised, sequential IEEE‑754‑style floating‑point multiplier; successor to the combinational float16 multiplier. Operand format is set by exponent and mantissa widths, with float16 as the default. Significands are multiplied by an iterative shift‑add datapath, one bit per cycle. Results are rounded to nearest‑even, special operands are handled, and exception flags are raised. Operands enter and results leave over valid/ready handshakes, so the block drops into streaming datapaths.

---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_classify.sv | 44 ++++
 rtl/fp_mul_iter.sv | 231 +++++++++++++++++++++++
 tb/tb_fp_mul_iter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the iterative floating-point multiplier.
//   fp_class_e     : operand classification (subnormals are reported as zero)
//   state_e        : control FSM states
//   FLAG_*         : bit positions inside the 4-bit flags word
//   fp_bias        : exponent bias for a given exponent width
//   fp_canon_qnan  : canonical quiet NaN bit pattern (zero-extended to 64 bits)
package fp_pkg;

    typedef enum logic [2:0] {
        ClsZero,
        ClsNormal,
        ClsInf,
        ClsQnan,
        ClsSnan
    } fp_class_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StRound,
        StOut
    } state_e;

    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // sign 0, exponent all ones, mantissa MSB set, remaining bits clear
    function automatic logic [63:0] fp_canon_qnan(input int unsigned exp_w,
                                                  input int unsigned man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 32'd1));
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand unpacker.
//   word_i : packed operand {sign, exp, man}
//   sign_o : sign bit
//   exp_o  : biased exponent field
//   sig_o  : significand with the hidden 1 prepended
//   cls_o  : operand class; subnormals are flushed to ClsZero
module fp_classify
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic [EXP_W+MAN_W:0] word_i,
    output logic                 sign_o,
    output logic [EXP_W-1:0]     exp_o,
    output logic [MAN_W:0]       sig_o,
    output fp_class_e            cls_o
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    always_comb begin
        exp_f  = word_i[EXP_W+MAN_W-1:MAN_W];
        man_f  = word_i[MAN_W-1:0];
        sign_o = word_i[EXP_W+MAN_W];
        exp_o  = exp_f;
        sig_o  = {1'b1, man_f};
        if (exp_f == '0) begin
            cls_o = ClsZero;
        end else if (&exp_f) begin
            if (man_f == '0) begin
                cls_o = ClsInf;
            end else if (man_f[MAN_W-1]) begin
                cls_o = ClsQnan;
            end else begin
                cls_o = ClsSnan;
            end
        end else begin
            cls_o = ClsNormal;
        end
    end

endmodule

// File: rtl/fp_mul_iter.sv
// Sequential IEEE-754-style multiplier, one significand bit per cycle.
//   clk, rst_n           : clock and asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only while idle)
//   a, b                 : operands {sign, exp, man}
//   out_valid / out_ready: result handshake; result and flags held until taken
//   result               : rounded (nearest-even) product
//   flags                : {invalid, overflow, underflow, inexact}
module fp_mul_iter
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);

    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned P     = 2 * MAN_W + 2;
    localparam int unsigned CNT_W = $clog2(MAN_W + 2);
    localparam int unsigned EW2   = EXP_W + 2;

    localparam logic [63:0]             QNAN64  = fp_canon_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]            QNAN_W  = QNAN64[W-1:0];
    localparam logic signed [EW2-1:0]   BIAS_S  = EW2'(fp_bias(EXP_W));
    localparam logic signed [EW2-1:0]   EXP_MAX = EW2'((2 ** EXP_W) - 1);

    state_e                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic signed [EW2-1:0]   exp_q, exp_d;
    logic [MAN_W:0]          siga_q, siga_d;
    logic [MAN_W:0]          sigb_q, sigb_d;
    logic [P-1:0]            acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [W-1:0]            result_q, result_d;
    logic [3:0]              flags_q, flags_d;

    logic                    sa, sb;
    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W:0]          siga_in, sigb_in;
    fp_class_e               cla, clb;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .word_i (a),
        .sign_o (sa),
        .exp_o  (ea),
        .sig_o  (siga_in),
        .cls_o  (cla)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .word_i (b),
        .sign_o (sb),
        .exp_o  (eb),
        .sig_o  (sigb_in),
        .cls_o  (clb)
    );

    logic accept;
    logic special;

    assign accept  = in_valid && in_ready;
    assign special = (cla != ClsNormal) || (clb != ClsNormal);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            siga_q   <= '0;
            sigb_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            siga_q   <= siga_d;
            sigb_q   <= sigb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = special ? StOut : StMul;
            StMul:   if (cnt_q == CNT_W'(MAN_W)) state_d = StRound;
            StRound: state_d = StOut;
            StOut:   if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- special operands
    logic [W-1:0] spec_res;
    logic [3:0]   spec_flags;
    logic         s_xor;

    always_comb begin
        s_xor      = sa ^ sb;
        spec_flags = '0;
        if (cla == ClsQnan || cla == ClsSnan || clb == ClsQnan || clb == ClsSnan) begin
            spec_res                 = QNAN_W;
            spec_flags[FLAG_INVALID] = (cla == ClsSnan) || (clb == ClsSnan);
        end else if ((cla == ClsInf && clb == ClsZero) || (cla == ClsZero && clb == ClsInf)) begin
            spec_res                 = QNAN_W;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (cla == ClsInf || clb == ClsInf) begin
            spec_res = {s_xor, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            spec_res = {s_xor, {(W - 1){1'b0}}};
        end
    end

    // ---------------------------------------------------------------- shift-add step
    // Adding into the upper half then shifting right keeps the partial product
    // aligned with sigB's weight; after MAN_W+1 steps acc holds the full product.
    logic [MAN_W+1:0] step_sum;
    logic [P-1:0]     acc_step;

    always_comb begin
        step_sum = {1'b0, acc_q[P-1:MAN_W+1]} + (sigb_q[0] ? {1'b0, siga_q} : '0);
        acc_step = {step_sum, acc_q[MAN_W:1]};
    end

    // ---------------------------------------------------------------- rounding
    logic                  msb, guard, sticky, inc, carry, inexact;
    logic [MAN_W-1:0]      kept_man, man_rnd;
    logic signed [EW2-1:0] e_fin;
    logic [W-1:0]          rnd_res;
    logic [3:0]            rnd_flags;

    always_comb begin
        msb = acc_q[P-1];
        // kept_man excludes the hidden bit, which is always 1 after normalisation
        if (msb) begin
            kept_man = acc_q[P-2:MAN_W+1];
            guard    = acc_q[MAN_W];
            sticky   = |acc_q[MAN_W-1:0];
        end else begin
            kept_man = acc_q[P-3:MAN_W];
            guard    = acc_q[MAN_W-1];
            sticky   = |acc_q[MAN_W-2:0];
        end
        inc     = guard && (sticky || kept_man[0]);
        carry   = inc && (&kept_man);
        man_rnd = kept_man + MAN_W'(inc);  // wraps to zero on carry-out
        inexact = guard || sticky;
        e_fin   = exp_q + $signed({{(EW2 - 1){1'b0}}, msb})
                        + $signed({{(EW2 - 1){1'b0}}, carry});

        rnd_flags = '0;
        if (e_fin >= EXP_MAX) begin
            rnd_res                  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags[FLAG_OVERFLOW] = 1'b1;
            rnd_flags[FLAG_INEXACT]  = 1'b1;
        end else if (e_fin[EW2-1] || (e_fin == '0)) begin
            rnd_res                   = {sign_q, {(W - 1){1'b0}}};
            rnd_flags[FLAG_UNDERFLOW] = 1'b1;
            rnd_flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            rnd_res                 = {sign_q, e_fin[EXP_W-1:0], man_rnd};
            rnd_flags[FLAG_INEXACT] = inexact;
        end
    end

    // ---------------------------------------------------------------- datapath next state
    always_comb begin
        sign_d   = sign_q;
        exp_d    = exp_q;
        siga_d   = siga_q;
        sigb_d   = sigb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    flags_d = '0;
                    if (special) begin
                        result_d = spec_res;
                        flags_d  = spec_flags;
                    end else begin
                        sign_d = sa ^ sb;
                        exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
                        siga_d = siga_in;
                        sigb_d = sigb_in;
                        acc_d  = '0;
                        cnt_d  = '0;
                    end
                end
            end
            StMul: begin
                acc_d  = acc_step;
                sigb_d = sigb_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
            StRound: begin
                result_d = rnd_res;
                flags_d  = rnd_flags;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        in_ready  = rst_n && (state_q == StIdle);
        out_valid = (state_q == StOut);
        result    = result_q;
        flags     = flags_q;
    end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Self-checking bench for fp_mul_iter: directed cases, randomized operands
// against an arithmetic reference model, backpressure, reset and float32.
module tb_fp_mul_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, result;
    logic [3:0]  flags;
    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] a32, b32, result32;
    logic [3:0]  flags32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_mul_iter #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    fp_mul_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .a         (a32),
        .b         (b32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .result    (result32),
        .flags     (flags32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 0 zero, 1 normal, 2 inf, 3 qnan, 4 snan
    function automatic int cls_of(input longint unsigned e, input longint unsigned m,
                                  input longint unsigned emax, input int mw);
        if (e == 0) return 0;
        if (e == emax) begin
            if (m == 0) return 2;
            if (((m >> (mw - 1)) & 64'd1) != 0) return 3;
            return 4;
        end
        return 1;
    endfunction

    // Exact integer product, rounded to nearest-even by remainder comparison.
    function automatic void ref_mul(input int ew, input int mw,
                                    input longint unsigned x, input longint unsigned y,
                                    output longint unsigned r, output logic [3:0] f,
                                    output bit nrm);
        longint unsigned emax, mmask, xe, ye, xm, ym, prod, q, rem, half, qn, sbit;
        longint          e;
        int              sh, cx, cy;
        bit              s;
        emax  = (64'd1 << ew) - 64'd1;
        mmask = (64'd1 << mw) - 64'd1;
        xe    = (x >> mw) & emax;
        ye    = (y >> mw) & emax;
        xm    = x & mmask;
        ym    = y & mmask;
        s     = (((x ^ y) >> (ew + mw)) & 64'd1) != 0;
        sbit  = s ? (64'd1 << (ew + mw)) : 64'd0;
        qn    = (emax << mw) | (64'd1 << (mw - 1));
        cx    = cls_of(xe, xm, emax, mw);
        cy    = cls_of(ye, ym, emax, mw);
        f     = 4'b0000;
        nrm   = 1'b0;
        if (cx >= 3 || cy >= 3) begin
            r = qn;
            f = {(cx == 4 || cy == 4), 3'b000};
        end else if ((cx == 2 && cy == 0) || (cx == 0 && cy == 2)) begin
            r = qn;
            f = 4'b1000;
        end else if (cx == 2 || cy == 2) begin
            r = sbit | (emax << mw);
        end else if (cx == 0 || cy == 0) begin
            r = sbit;
        end else begin
            nrm  = 1'b1;
            prod = (xm | (64'd1 << mw)) * (ym | (64'd1 << mw));
            sh   = (prod >= (64'd1 << (2 * mw + 1))) ? mw + 1 : mw;
            q    = prod >> sh;
            rem  = prod - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            e = longint'(xe + ye) - longint'(emax >> 1) + longint'(sh - mw);
            if (q == (64'd2 << mw)) begin
                q = q >> 1;
                e++;
            end
            if (e >= longint'(emax)) begin
                r = sbit | (emax << mw);
                f = 4'b0101;
            end else if (e <= 0) begin
                r = sbit;
                f = 4'b0011;
            end else begin
                r = sbit | ($unsigned(e) << mw) | (q & mmask);
                f = {3'b000, rem != 0};
            end
        end
    endfunction

    task automatic run16(input logic [15:0] xa, input logic [15:0] xb, input int hold,
                         input string tag);
        longint unsigned er;
        logic [3:0]      ef;
        bit              nrm;
        int              lat, n;
        ref_mul(5, 10, 64'(xa), 64'(xb), er, ef, nrm);
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        chk({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), nrm ? 64'd13 : 64'd1);
        chk({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
        chk({tag, " result"}, 64'(result), er);
        chk({tag, " flags"}, 64'(flags), 64'(ef));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            step();
            chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
            chk({tag, " hold result"}, 64'(result), er);
            chk({tag, " hold flags"}, 64'(flags), 64'(ef));
            chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " valid drop"}, 64'(out_valid), 64'd0);
        chk({tag, " ready rise"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run32(input logic [31:0] xa, input logic [31:0] xb, input string tag);
        longint unsigned er;
        logic [3:0]      ef;
        bit              nrm;
        int              lat, n;
        ref_mul(8, 23, 64'(xa), 64'(xb), er, ef, nrm);
        n = 0;
        while (!in_ready32 && n < 60) begin
            step();
            n++;
        end
        chk({tag, " in_ready idle"}, 64'(in_ready32), 64'd1);
        a32        = xa;
        b32        = xb;
        in_valid32 = 1'b1;
        step();
        in_valid32 = 1'b0;
        lat        = 1;
        while (!out_valid32 && lat < 60) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), nrm ? 64'd26 : 64'd1);
        chk({tag, " result"}, 64'(result32), er);
        chk({tag, " flags"}, 64'(flags32), 64'(ef));
        out_ready32 = 1'b1;
        step();
        out_ready32 = 1'b0;
        chk({tag, " ready rise"}, 64'(in_ready32), 64'd1);
    endtask

    initial begin
        int hits;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        in_valid32  = 1'b0;
        out_ready32 = 1'b0;
        a32         = '0;
        b32         = '0;
        #12;
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        step();
        chk("post rst in_ready", 64'(in_ready), 64'd1);

        run16(16'h3C00, 16'h4000, 0, "1x2");
        run16(16'h4200, 16'h4400, 0, "3x4");
        run16(16'hC000, 16'h4000, 0, "neg2x2");
        run16(16'h3C01, 16'h3C01, 0, "round");
        run16(16'h7BFF, 16'h4000, 0, "overflow");
        run16(16'h0400, 16'h3800, 0, "underflow");
        run16(16'h7C00, 16'h0000, 0, "inf_x_zero");
        run16(16'h7D00, 16'h3C00, 0, "snan");
        run16(16'hFC00, 16'h4000, 0, "neg_inf");
        run16(16'h4200, 16'h4400, 5, "backpressure");

        for (int i = 0; i < 40; i++) begin
            run16(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), "random");
        end

        // Reset in the middle of MUL: nothing may emerge afterwards.
        run16(16'h4200, 16'h4400, 0, "pre_reset");
        a        = 16'h3C00;
        b        = 16'h3C00;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", 64'(out_valid), 64'd0);
        chk("mid reset result", 64'(result), 64'd0);
        chk("mid reset flags", 64'(flags), 64'd0);
        chk("mid reset in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b1;
        #2;
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) hits++;
        end
        chk("no stale out_valid", 64'(hits), 64'd0);
        run16(16'h3C00, 16'h3C00, 0, "post_reset 1x1");

        run32(32'h3F800000, 32'h40000000, "f32 1x2");
        for (int i = 0; i < 6; i++) begin
            run32($urandom, $urandom, "f32 random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
